aead_serial_host: RTL and testbench
===================================

# aead_serial_host

Host-side driver for the bit-serial AEAD core: accepts parallel key/nonce/AD/PT words plus a start pulse, serialises them MSB-first onto the core's serial inputs, and pulses the encryption or decryption start line. It then waits for the matching ready flag, deserialises the core's serial output and tag back into parallel registers, and reports completion to the system. It sits between a register/bus front end and the AEAD core, which it drives from the other end of the core's serial interface.

## Interface
Parameters:
- K, 128, key width in bits; K ≥ 128
- L, 40, associated-data width
- Y, 40, plaintext/ciphertext width
- START_CYCLES, 5, cycles the start line is held high
- GAP, 4, idle cycles between the ready flag and the first unload sample
- TIMEOUT, 4096, maximum cycles to wait for the ready flag
- N (derived), max(K, L, Y), serial frame length

Ports:
- clk  in  1  clock (one clock domain)
- rst  in  1  asynchronous, active-low reset
- start  in  1  request; accepted only in IDLE
- mode  in  1  0 = encrypt, 1 = decrypt
- key  in  K;  nonce  in  128;  ad  in  L;  pt  in  Y  operands, sampled on accept
- rnd  in  2  per-cycle randomness forwarded to r128_so/rpt_so
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  ready timeout occurred; valid with done
- data_out  out  Y  ciphertext (encrypt) or recovered plaintext (decrypt)
- tag_out  out  128  captured tag
- auth  out  1  authentication flag captured in decrypt mode
- key_so, nonce_so, ad_so, pt_so, r128_so, rpt_so  out  1  serial operands to the core
- enc_start, dec_start  out  1  core start lines
- enc_ready, dec_ready  in  1  core completion flags
- data_si, tag_si, auth_si  in  1  serial data, serial tag and auth flag from the core

## Operation
- FSM: IDLE → LOAD → STRT → WAIT → GAP → UNLD → DONE → IDLE. In decrypt mode the FSM goes IDLE → STRT directly; no operands are loaded.
- IDLE: when start=1, latch the operands into shift registers, clear err, clear the counter, and select the next state by mode. A start pulse while busy=1 is ignored.
- LOAD (N cycles, counter i = 0..N-1). Each output bit is registered:
  - key_so = key[K-1-i]
  - nonce_so = nonce[127-i] for i < 128, else 0
  - ad_so = ad[L-1-i] for i < L, else 0
  - pt_so = pt[Y-1-i] for i < Y, else 0
  - {r128_so, rpt_so} = rnd
- STRT (START_CYCLES cycles): enc_start=1 (mode 0) or dec_start=1 (mode 1). All serial outputs are 0.
- WAIT: watch enc_ready (mode 0) or dec_ready (mode 1).
  - On ready=1, go to GAP.
  - If the counter reaches TIMEOUT-1 with ready still low, set err=1 and go to DONE, skipping the unload.
- GAP: GAP cycles, nothing sampled.
- UNLD (N cycles, i = 0..N-1): on each clock edge, data_out[i] ← data_si for i < Y and tag_out[i] ← tag_si for i < 128. The captured word is bit-reversed relative to LOAD order.
  - Mode 1: on the last UNLD edge, auth ← auth_si.
  - Mode 0: auth ← 0.
- DONE: done=1 for one cycle, then IDLE.
- data_out, tag_out and auth hold their values until the next accepted start. The register bits are cleared on accept.
- Counter width is clog2(max(N, TIMEOUT, START_CYCLES, GAP)). It resets to 0 on every state change and never wraps inside a state.

## Timing
- Reset (rst=0, asynchronous): FSM goes to IDLE, and every output and internal register goes to 0, including busy, done, err, data_out, tag_out, auth and all start/serial lines. Reset mid-operation aborts with no done pulse.
- Accept at edge E0: busy=1 and the first LOAD bit are visible after E0. Bit i is valid during the cycle following edge E0+i.
- The start line rises after edge E0+N (encrypt) or E0 (decrypt) and stays high for exactly START_CYCLES cycles.
- Ready is sampled registered: ready high at edge Er moves the FSM to GAP. The first UNLD sample is taken at edge Er+GAP+1.
- Encrypt total latency from accept to done rising: N + START_CYCLES + W + GAP + N + 1 cycles, where W is the number of WAIT cycles including the ready cycle.
- Ready asserted during STRT is not seen; WAIT samples only after STRT ends. The core must hold ready high until it is sampled.

## Test plan
- Encrypt load, K=128, L=Y=40, key=0x000102…0F, nonce=0xF0E1…, ad=0x0123456789, pt=0xA5A5A5A5A5 → a serial-capture model reconstructs all four operands exactly over 128 cycles; enc_start is high for exactly 5 cycles; dec_start stays 0.
- Core model raises enc_ready 20 cycles after enc_start falls, then drives data_si/tag_si from the patterns 0xC3C3C3C3C3 and 0x0F…0F, bit i on cycle i → data_out and tag_out match those patterns; done pulses once; err=0; accept-to-done latency = 128+5+W+4+128+1.
- Decrypt mode with auth_si=1 → no LOAD cycles; dec_start is high for 5 cycles; auth=1, data_out captured, done pulses once.
- Ready never asserted → after TIMEOUT wait cycles, err=1 and done=1 in the same cycle; data_out/tag_out stay 0.
- Second start pulse issued mid-LOAD → ignored; the serial stream and result equal those of a single run.
- rst driven low mid-UNLD → all outputs are 0 immediately (asynchronously); no done pulse; a new start after release runs a full, correct transaction.

Source files
------------

// File: rtl/aead_serial_host.sv
// Host-side driver for the bit-serial AEAD core: shifts operands out MSB-first, pulses the
// core start line, waits for ready and deserialises the returned data, tag and auth flag.
module aead_serial_host #(
  parameter int unsigned K            = 128,
  parameter int unsigned L            = 40,
  parameter int unsigned Y            = 40,
  parameter int unsigned START_CYCLES = 5,
  parameter int unsigned GAP          = 4,
  parameter int unsigned TIMEOUT      = 4096
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic         i_mode,
  input  logic [K-1:0] i_key,
  input  logic [127:0] i_nonce,
  input  logic [L-1:0] i_ad,
  input  logic [Y-1:0] i_pt,
  input  logic [1:0]   i_rnd,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_err,
  output logic [Y-1:0] o_data_out,
  output logic [127:0] o_tag_out,
  output logic         o_auth,
  output logic         o_key_so,
  output logic         o_nonce_so,
  output logic         o_ad_so,
  output logic         o_pt_so,
  output logic         o_r128_so,
  output logic         o_rpt_so,
  output logic         o_enc_start,
  output logic         o_dec_start,
  input  logic         i_enc_ready,
  input  logic         i_dec_ready,
  input  logic         i_data_si,
  input  logic         i_tag_si,
  input  logic         i_auth_si
);
  localparam int unsigned N  = (K > L) ? ((K > Y) ? K : Y) : ((L > Y) ? L : Y);
  localparam int unsigned M1 = (N > TIMEOUT) ? N : TIMEOUT;
  localparam int unsigned M2 = (START_CYCLES > GAP) ? START_CYCLES : GAP;
  localparam int unsigned CW = $clog2((M1 > M2) ? M1 : M2);

  localparam logic [CW-1:0] LastFrame = CW'(N - 1);
  localparam logic [CW-1:0] LastStrt  = CW'(START_CYCLES - 1);
  localparam logic [CW-1:0] LastWait  = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] LastGap   = CW'(GAP - 1);
  localparam logic [CW-1:0] LastData  = CW'(Y - 1);
  localparam logic [CW-1:0] LastTag   = CW'(127);

  typedef enum logic [2:0] {StIdle, StLoad, StStrt, StWait, StGap, StUnld, StDone} state_e;

  state_e        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_mode, r_busy, r_done, r_err, r_auth;
  logic [K-1:0]  r_key_sh;
  logic [127:0]  r_nonce_sh, r_tag;
  logic [L-1:0]  r_ad_sh;
  logic [Y-1:0]  r_pt_sh, r_data;
  logic          r_key_so, r_nonce_so, r_ad_so, r_pt_so, r_r128_so, r_rpt_so;
  logic          r_enc_start, r_dec_start;
  logic          w_ready;

  assign w_ready = r_mode ? i_dec_ready : i_enc_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_mode      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_auth      <= 1'b0;
      r_key_sh    <= '0;
      r_nonce_sh  <= '0;
      r_ad_sh     <= '0;
      r_pt_sh     <= '0;
      r_data      <= '0;
      r_tag       <= '0;
      r_key_so    <= 1'b0;
      r_nonce_so  <= 1'b0;
      r_ad_so     <= 1'b0;
      r_pt_so     <= 1'b0;
      r_r128_so   <= 1'b0;
      r_rpt_so    <= 1'b0;
      r_enc_start <= 1'b0;
      r_dec_start <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_mode     <= i_mode;
            r_busy     <= 1'b1;
            r_err      <= 1'b0;
            r_auth     <= 1'b0;
            r_data     <= '0;
            r_tag      <= '0;
            r_cnt      <= '0;
            // Bit 0 of the frame goes out on the accept edge; the rest shift from here.
            r_key_sh   <= i_key << 1;
            r_nonce_sh <= i_nonce << 1;
            r_ad_sh    <= i_ad << 1;
            r_pt_sh    <= i_pt << 1;
            if (i_mode) begin
              r_state     <= StStrt;
              r_dec_start <= 1'b1;
            end else begin
              r_state                <= StLoad;
              r_key_so               <= i_key[K-1];
              r_nonce_so             <= i_nonce[127];
              r_ad_so                <= i_ad[L-1];
              r_pt_so                <= i_pt[Y-1];
              {r_r128_so, r_rpt_so}  <= i_rnd;
            end
          end
        end
        StLoad: begin
          if (r_cnt == LastFrame) begin
            r_state     <= StStrt;
            r_cnt       <= '0;
            r_key_so    <= 1'b0;
            r_nonce_so  <= 1'b0;
            r_ad_so     <= 1'b0;
            r_pt_so     <= 1'b0;
            r_r128_so   <= 1'b0;
            r_rpt_so    <= 1'b0;
            r_enc_start <= 1'b1;
          end else begin
            r_cnt                 <= r_cnt + 1'b1;
            r_key_so              <= r_key_sh[K-1];
            r_nonce_so            <= r_nonce_sh[127];
            r_ad_so               <= r_ad_sh[L-1];
            r_pt_so               <= r_pt_sh[Y-1];
            {r_r128_so, r_rpt_so} <= i_rnd;
            r_key_sh              <= r_key_sh << 1;
            r_nonce_sh            <= r_nonce_sh << 1;
            r_ad_sh               <= r_ad_sh << 1;
            r_pt_sh               <= r_pt_sh << 1;
          end
        end
        StStrt: begin
          if (r_cnt == LastStrt) begin
            r_state     <= StWait;
            r_cnt       <= '0;
            r_enc_start <= 1'b0;
            r_dec_start <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StWait: begin
          if (w_ready) begin
            r_state <= StGap;
            r_cnt   <= '0;
          end else if (r_cnt == LastWait) begin
            r_state <= StDone;
            r_cnt   <= '0;
            r_err   <= 1'b1;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StGap: begin
          if (r_cnt == LastGap) begin
            r_state <= StUnld;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StUnld: begin
          // Right-shift capture lands sample i in bit i once the word is complete.
          if (r_cnt <= LastData) r_data <= {i_data_si, r_data[Y-1:1]};
          if (r_cnt <= LastTag)  r_tag  <= {i_tag_si, r_tag[127:1]};
          if (r_cnt == LastFrame) begin
            r_state <= StDone;
            r_cnt   <= '0;
            r_auth  <= r_mode & i_auth_si;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_err       = r_err;
  assign o_data_out  = r_data;
  assign o_tag_out   = r_tag;
  assign o_auth      = r_auth;
  assign o_key_so    = r_key_so;
  assign o_nonce_so  = r_nonce_so;
  assign o_ad_so     = r_ad_so;
  assign o_pt_so     = r_pt_so;
  assign o_r128_so   = r_r128_so;
  assign o_rpt_so    = r_rpt_so;
  assign o_enc_start = r_enc_start;
  assign o_dec_start = r_dec_start;

endmodule

// File: tb/tb_aead_serial_host.sv
// Bench for aead_serial_host: drives transactions against a small core model and checks the
// serial stream, start pulses, captured results and latency against the timing rules.
module tb_aead_serial_host;
  localparam int unsigned K = 128, L = 40, Y = 40, SC = 5, GP = 4, TO = 4096, N = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, start, mode;
  logic [K-1:0] key;
  logic [127:0] nonce;
  logic [L-1:0] ad;
  logic [Y-1:0] pt;
  logic [1:0]   rnd;
  logic         busy, done, err, auth;
  logic [Y-1:0] data_out;
  logic [127:0] tag_out;
  logic         key_so, nonce_so, ad_so, pt_so, r128_so, rpt_so, enc_start, dec_start;
  logic         enc_ready, dec_ready, data_si, tag_si, auth_si;

  aead_serial_host #(
    .K(K), .L(L), .Y(Y), .START_CYCLES(SC), .GAP(GP), .TIMEOUT(TO)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_mode(mode), .i_key(key),
    .i_nonce(nonce), .i_ad(ad), .i_pt(pt), .i_rnd(rnd), .o_busy(busy), .o_done(done),
    .o_err(err), .o_data_out(data_out), .o_tag_out(tag_out), .o_auth(auth),
    .o_key_so(key_so), .o_nonce_so(nonce_so), .o_ad_so(ad_so), .o_pt_so(pt_so),
    .o_r128_so(r128_so), .o_rpt_so(rpt_so), .o_enc_start(enc_start),
    .o_dec_start(dec_start), .i_enc_ready(enc_ready), .i_dec_ready(dec_ready),
    .i_data_si(data_si), .i_tag_si(tag_si), .i_auth_si(auth_si)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  // Observations of the last transaction
  logic [N-1:0] cap_key, cap_nonce, cap_ad, cap_pt;
  int obs_load, obs_enc_hi, obs_dec_hi, obs_done, obs_lat, obs_ws, obs_rnd_bad, obs_stray;
  logic obs_err, obs_auth, obs_busy_at_done, obs_hung, obs_rst_zero;
  logic [Y-1:0] obs_data;
  logic [127:0] obs_tag;

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [Y-1:0] rand40();
    return Y'({$urandom(), $urandom()});
  endfunction

  // Drive one transaction and let a simple core model answer it; ready goes high rdy_delay
  // cycles into WAIT (negative: never), reset fires at unload sample rst_j (negative: never).
  task automatic run_txn(input bit md, input logic [K-1:0] k, input logic [127:0] nc,
                         input logic [L-1:0] a, input logic [Y-1:0] p,
                         input logic [Y-1:0] dpat, input logic [127:0] tpat, input bit au,
                         input int rdy_delay, input int poke_t, input int rst_j);
    int t, c0, ws, tr, fs, j, done_t, rst_rel;
    bit seen_start;
    logic [1:0] prev_rnd;
    cap_key = '0; cap_nonce = '0; cap_ad = '0; cap_pt = '0;
    obs_load = 0; obs_enc_hi = 0; obs_dec_hi = 0; obs_done = 0; obs_lat = -1; obs_ws = -1;
    obs_rnd_bad = 0; obs_stray = 0; obs_err = 0; obs_auth = 0; obs_busy_at_done = 0;
    obs_hung = 0; obs_rst_zero = 0; obs_data = '0; obs_tag = '0;
    seen_start = 0; ws = -1; tr = -1; fs = -1; done_t = -1; rst_rel = -1;
    @(negedge clk);
    mode = md; key = k; nonce = nc; ad = a; pt = p; start = 1'b1;
    rnd = 2'($urandom()); prev_rnd = rnd; c0 = cyc;
    forever begin
      @(negedge clk);
      t = cyc - c0;
      if (enc_start) obs_enc_hi++;
      if (dec_start) obs_dec_hi++;
      if (enc_start || dec_start) seen_start = 1;
      else if (seen_start && ws < 0) ws = t;
      if (busy && !seen_start) begin
        cap_key = {cap_key[N-2:0], key_so};     cap_nonce = {cap_nonce[N-2:0], nonce_so};
        cap_ad  = {cap_ad[N-2:0], ad_so};       cap_pt    = {cap_pt[N-2:0], pt_so};
        obs_load++;
        if ({r128_so, rpt_so} !== prev_rnd) obs_rnd_bad++;
      end else if ({key_so, nonce_so, ad_so, pt_so, r128_so, rpt_so} !== 6'b0) begin
        obs_stray++;
      end
      if (done === 1'b1) begin
        obs_done++;
        if (done_t < 0) begin
          done_t = t; obs_lat = t; obs_err = err; obs_data = data_out; obs_tag = tag_out;
          obs_auth = auth; obs_busy_at_done = busy;
        end
      end
      start = (t == poke_t);
      if (t == poke_t) begin
        mode = ~md; key = rand128(); nonce = rand128(); ad = rand40(); pt = rand40();
      end
      rnd = 2'($urandom()); prev_rnd = rnd;
      if (rdy_delay >= 0 && ws >= 0 && t == ws + rdy_delay) begin
        tr = t; fs = t + GP + 1;
      end
      enc_ready = (tr == t) && !md;
      dec_ready = (tr == t) && md;
      j = t - fs;
      data_si = (fs >= 0 && j >= 0 && j < Y) ? dpat[j] : 1'b0;
      tag_si  = (fs >= 0 && j >= 0 && j < 128) ? tpat[j] : 1'b0;
      auth_si = (fs >= 0 && j == N - 1) ? au : ~au;
      obs_ws = ws;
      if (rst_j >= 0 && fs >= 0 && j == rst_j) begin
        rst_n = 1'b0;
        #1;
        obs_rst_zero = ({busy, done, err, data_out, tag_out, auth, key_so, nonce_so, ad_so,
                         pt_so, r128_so, rpt_so, enc_start, dec_start} === '0);
        rst_rel = t + 2;
      end
      if (t == rst_rel) rst_n = 1'b1;
      if (done_t >= 0 && t >= done_t + 3) break;
      if (rst_rel >= 0 && t >= rst_rel + 20) break;
      if (t > 6000) begin obs_hung = 1; break; end
    end
    start = 0; enc_ready = 0; dec_ready = 0; data_si = 0; tag_si = 0; auth_si = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; mode = 0; key = '0; nonce = '0; ad = '0; pt = '0; rnd = '0;
    enc_ready = 0; dec_ready = 0; data_si = 0; tag_si = 0; auth_si = 0;
    repeat (3) @(negedge clk);
    total++; if ({busy, done, err} !== 3'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 000", {busy, done, err}); end
    total++; if ({data_out, tag_out, auth} !== '0) begin
      bad++; $display("FAIL reset_results: got %h %h %b want 0", data_out, tag_out, auth); end
    total++; if ({key_so, nonce_so, ad_so, pt_so, r128_so, rpt_so, enc_start, dec_start} !== 8'b0)
      begin bad++; $display("FAIL reset_lines: got %b want 0",
        {key_so, nonce_so, ad_so, pt_so, r128_so, rpt_so, enc_start, dec_start}); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_encrypt_directed();
    logic [K-1:0] k;  logic [127:0] nc, tp;  logic [L-1:0] a;  logic [Y-1:0] p, dp;
    k = 128'h000102030405060708090A0B0C0D0E0F; nc = 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F;
    a = 40'h0123456789; p = 40'hA5A5A5A5A5; dp = 40'hC3C3C3C3C3; tp = {16{8'h0F}};
    run_txn(1'b0, k, nc, a, p, dp, tp, 1'b1, 20, -1, -1);
    total++; if (obs_hung) begin bad++; $display("FAIL enc_hang: got hung want done"); end
    total++; if (cap_key !== k) begin bad++; $display("FAIL enc_key: got %h want %h", cap_key, k); end
    total++; if (cap_nonce !== nc) begin bad++; $display("FAIL enc_nonce: got %h want %h", cap_nonce, nc); end
    total++; if (cap_ad !== {a, {(N-L){1'b0}}}) begin
      bad++; $display("FAIL enc_ad: got %h want %h", cap_ad, {a, {(N-L){1'b0}}}); end
    total++; if (cap_pt !== {p, {(N-Y){1'b0}}}) begin
      bad++; $display("FAIL enc_pt: got %h want %h", cap_pt, {p, {(N-Y){1'b0}}}); end
    total++; if (obs_load !== N) begin bad++; $display("FAIL enc_load_len: got %0d want %0d", obs_load, N); end
    total++; if (obs_rnd_bad !== 0 || obs_stray !== 0) begin
      bad++; $display("FAIL enc_rnd_stray: got %0d/%0d want 0/0", obs_rnd_bad, obs_stray); end
    total++; if (obs_enc_hi !== SC || obs_dec_hi !== 0) begin
      bad++; $display("FAIL enc_start_len: got %0d/%0d want %0d/0", obs_enc_hi, obs_dec_hi, SC); end
    total++; if (obs_data !== dp) begin bad++; $display("FAIL enc_data: got %h want %h", obs_data, dp); end
    total++; if (obs_tag !== tp) begin bad++; $display("FAIL enc_tag: got %h want %h", obs_tag, tp); end
    total++; if (obs_done !== 1 || obs_err !== 1'b0 || obs_auth !== 1'b0 || obs_busy_at_done !== 1'b1)
      begin bad++; $display("FAIL enc_done: got done=%0d err=%b auth=%b busy=%b want 1 0 0 1",
        obs_done, obs_err, obs_auth, obs_busy_at_done); end
    total++; if (obs_lat !== N + SC + 21 + GP + N + 1) begin
      bad++; $display("FAIL enc_latency: got %0d want %0d", obs_lat, N + SC + 21 + GP + N + 1); end
  endtask

  task automatic test_decrypt();
    logic [Y-1:0] dp;  logic [127:0] tp;
    dp = rand40(); tp = rand128();
    run_txn(1'b1, rand128(), rand128(), rand40(), rand40(), dp, tp, 1'b1, 7, -1, -1);
    total++; if (obs_load !== 0 || obs_stray !== 0) begin
      bad++; $display("FAIL dec_no_load: got %0d/%0d want 0/0", obs_load, obs_stray); end
    total++; if (obs_dec_hi !== SC || obs_enc_hi !== 0 || obs_ws !== SC + 1) begin
      bad++; $display("FAIL dec_start: got %0d/%0d ws=%0d want %0d/0 ws=%0d",
        obs_dec_hi, obs_enc_hi, obs_ws, SC, SC + 1); end
    total++; if (obs_auth !== 1'b1) begin bad++; $display("FAIL dec_auth: got %b want 1", obs_auth); end
    total++; if (obs_data !== dp || obs_tag !== tp) begin
      bad++; $display("FAIL dec_result: got %h %h want %h %h", obs_data, obs_tag, dp, tp); end
    total++; if (obs_done !== 1 || obs_lat !== SC + 8 + GP + N + 1) begin
      bad++; $display("FAIL dec_done: got %0d lat=%0d want 1 lat=%0d", obs_done, obs_lat,
        SC + 8 + GP + N + 1); end
  endtask

  task automatic test_timeout();
    run_txn(1'b0, rand128(), rand128(), rand40(), rand40(), rand40(), rand128(), 1'b0, -1, -1, -1);
    total++; if (obs_hung) begin bad++; $display("FAIL to_hang: got hung want done"); end
    total++; if (obs_err !== 1'b1 || obs_done !== 1) begin
      bad++; $display("FAIL to_err: got err=%b done=%0d want 1 1", obs_err, obs_done); end
    total++; if (obs_ws !== N + SC + 1 || obs_lat !== obs_ws + TO) begin
      bad++; $display("FAIL to_latency: got ws=%0d lat=%0d want ws=%0d lat=%0d", obs_ws, obs_lat,
        N + SC + 1, N + SC + 1 + TO); end
    total++; if (obs_data !== '0 || obs_tag !== '0) begin
      bad++; $display("FAIL to_results: got %h %h want 0 0", obs_data, obs_tag); end
  endtask

  task automatic test_start_ignored();
    logic [K-1:0] k;  logic [127:0] nc, tp;  logic [L-1:0] a;  logic [Y-1:0] p, dp;
    k = rand128(); nc = rand128(); a = rand40(); p = rand40(); dp = rand40(); tp = rand128();
    run_txn(1'b0, k, nc, a, p, dp, tp, 1'b0, 3, 30, -1);
    total++; if (cap_key !== k || cap_nonce !== nc) begin
      bad++; $display("FAIL poke_stream: got %h %h want %h %h", cap_key, cap_nonce, k, nc); end
    total++; if (cap_ad !== {a, {(N-L){1'b0}}} || cap_pt !== {p, {(N-Y){1'b0}}}) begin
      bad++; $display("FAIL poke_adpt: got %h %h", cap_ad, cap_pt); end
    total++; if (obs_enc_hi !== SC || obs_dec_hi !== 0 || obs_done !== 1) begin
      bad++; $display("FAIL poke_ctrl: got %0d/%0d/%0d want %0d/0/1", obs_enc_hi, obs_dec_hi,
        obs_done, SC); end
    total++; if (obs_data !== dp || obs_tag !== tp || obs_lat !== N + SC + 4 + GP + N + 1) begin
      bad++; $display("FAIL poke_result: got %h %h lat=%0d want %h %h lat=%0d", obs_data, obs_tag,
        obs_lat, dp, tp, N + SC + 4 + GP + N + 1); end
  endtask

  task automatic test_reset_mid_unload();
    logic [Y-1:0] dp;  logic [127:0] tp;
    run_txn(1'b1, rand128(), rand128(), rand40(), rand40(), {Y{1'b1}}, {128{1'b1}}, 1'b1, 2, -1, 10);
    total++; if (obs_rst_zero !== 1'b1) begin bad++; $display("FAIL rst_async: got %b want 1", obs_rst_zero); end
    total++; if (obs_done !== 0) begin bad++; $display("FAIL rst_no_done: got %0d want 0", obs_done); end
    dp = rand40(); tp = rand128();
    run_txn(1'b0, rand128(), rand128(), rand40(), rand40(), dp, tp, 1'b1, 0, -1, -1);
    total++; if (obs_data !== dp || obs_tag !== tp || obs_done !== 1 || obs_err !== 1'b0) begin
      bad++; $display("FAIL rst_rerun: got %h %h done=%0d err=%b want %h %h 1 0", obs_data, obs_tag,
        obs_done, obs_err, dp, tp); end
  endtask

  task automatic test_random();
    bit md, au;  int d, exp_lat;  logic [K-1:0] k;  logic [127:0] nc, tp;
    logic [L-1:0] a;  logic [Y-1:0] p, dp;
    for (int it = 0; it < 5; it++) begin
      md = 1'($urandom()); au = 1'($urandom()); d = int'($urandom_range(0, 30));
      k = rand128(); nc = rand128(); a = rand40(); p = rand40(); dp = rand40(); tp = rand128();
      run_txn(md, k, nc, a, p, dp, tp, au, d, -1, -1);
      exp_lat = (md ? 0 : N) + SC + (d + 1) + GP + N + 1;
      total++; if (obs_data !== dp || obs_tag !== tp) begin
        bad++; $display("FAIL rnd_result[%0d]: got %h %h want %h %h", it, obs_data, obs_tag, dp, tp); end
      total++; if (obs_auth !== (md & au) || obs_err !== 1'b0 || obs_done !== 1) begin
        bad++; $display("FAIL rnd_flags[%0d]: got auth=%b err=%b done=%0d want %b 0 1", it,
          obs_auth, obs_err, obs_done, md & au); end
      total++; if (obs_lat !== exp_lat) begin
        bad++; $display("FAIL rnd_latency[%0d]: got %0d want %0d", it, obs_lat, exp_lat); end
      total++; if (obs_load !== (md ? 0 : N) || obs_rnd_bad !== 0 || obs_stray !== 0) begin
        bad++; $display("FAIL rnd_stream[%0d]: got load=%0d rnd=%0d stray=%0d", it, obs_load,
          obs_rnd_bad, obs_stray); end
      total++; if (!md && (cap_key !== k || cap_nonce !== nc)) begin
        bad++; $display("FAIL rnd_ops[%0d]: got %h %h want %h %h", it, cap_key, cap_nonce, k, nc); end
    end
  endtask

  initial begin
    test_reset();
    test_encrypt_directed();
    test_decrypt();
    test_timeout();
    test_start_ignored();
    test_reset_mid_unload();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
